// File: rtl/tt_proj_ctrl.sv
// Project mux controller: pad-driven select counter, enable/settle FSM and per-project I/O routing.
// Define TT_PROJ_CTRL_SYNC2_EN for a 2-flop ctrl synchronizer; the default build uses a single flop.
module tt_proj_ctrl #(
    parameter int NUM_PROJ   = 8,
    parameter int SEL_W      = 3,
    parameter int SETTLE_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctrl_sel_rst,
    input  logic                   ctrl_sel_inc,
    input  logic                   ctrl_ena,
    input  logic                   pad_clk,
    input  logic                   pad_rst_n,
    input  logic [7:0]             pad_ui_in,
    input  logic [7:0]             pad_uio_in,
    output logic [7:0]             pad_uo_out,
    output logic [7:0]             pad_uio_out,
    output logic [7:0]             pad_uio_oe,
    output logic [NUM_PROJ-1:0]    proj_ena,
    output logic [NUM_PROJ*18-1:0] proj_iw,
    input  logic [NUM_PROJ*24-1:0] proj_ow,
    output logic [SEL_W-1:0]       sel_addr,
    output logic                   busy
);
    localparam int CNT_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, ACTIVE} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] settle_q;
    logic             block_q;
    logic [2:0]       ctrl_raw;
    logic [2:0]       ctrl_s;
    logic [2:0]       hist_q;
    logic [2:0]       ctrl_edge;
    logic             ctrl_vld;
    logic [23:0]      sel_ow;

    // Bit order: [2] ena, [1] sel_inc, [0] sel_rst.
    assign ctrl_raw = {ctrl_ena, ctrl_sel_inc, ctrl_sel_rst};

`ifdef TT_PROJ_CTRL_SYNC2_EN
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic [1:0] vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            vld_q  <= '0;
        end else begin
            meta_q <= ctrl_raw;
            sync_q <= meta_q;
            vld_q  <= {vld_q[0], 1'b1};
        end
    end

    assign ctrl_vld = vld_q[1];
`else
    logic [2:0] sync_q;
    logic       vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            sync_q <= ctrl_raw;
            vld_q  <= 1'b1;
        end
    end

    assign ctrl_vld = vld_q;
`endif

    assign ctrl_s = sync_q;

    always_ff @(posedge clk) begin
        if (rst) hist_q <= '0;
        else     hist_q <= ctrl_s;
    end

    assign ctrl_edge = ctrl_s & ~hist_q;

    // block_q stops a ctrl_ena held high across reset from looking like a fresh rising edge:
    // it only clears once a post-reset synchronized sample of ctrl_ena reads low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel_q    <= '0;
            settle_q <= '0;
            block_q  <= 1'b1;
            {pad_uio_oe, pad_uio_out, pad_uo_out} <= '0;
        end else begin
            {pad_uio_oe, pad_uio_out, pad_uo_out} <= '0;
            if (block_q && ctrl_vld && !ctrl_s[2]) block_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_edge[0])
                        sel_q <= '0;
                    else if (ctrl_edge[1])
                        sel_q <= (sel_q == SEL_W'(NUM_PROJ - 1)) ? '0 : sel_q + SEL_W'(1);
                    if (ctrl_edge[2] && !block_q) begin
                        state    <= HOLD;
                        settle_q <= CNT_W'(SETTLE_CYC - 1);
                    end
                end
                HOLD: begin
                    if (!ctrl_s[2])              state    <= IDLE;
                    else if (settle_q == '0)     state    <= ACTIVE;
                    else                         settle_q <= settle_q - CNT_W'(1);
                end
                ACTIVE: begin
                    if (!ctrl_s[2]) state <= IDLE;
                    else            {pad_uio_oe, pad_uio_out, pad_uo_out} <= sel_ow;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        proj_ena = '0;
        proj_iw  = '0;
        sel_ow   = '0;
        for (int unsigned p = 0; p < NUM_PROJ; p++) begin
            if (sel_q == SEL_W'(p)) begin
                sel_ow = proj_ow[p*24 +: 24];
                if (state != IDLE) begin
                    proj_ena[p] = 1'b1;
                    proj_iw[p*18 +: 18] = (state == ACTIVE) ?
                        {pad_uio_in, pad_ui_in, pad_rst_n, pad_clk} :
                        {16'h0000, 1'b0, pad_clk};
                end
            end
        end
    end

    assign sel_addr = sel_q;
    assign busy     = (state != IDLE);

endmodule
